// File: rtl/sub_shift_rows.sv
// Byte-serial SubBytes+ShiftRows (or inverse) stage of the low-area AES-128 core.
// One shared S-box lookup per cycle; 16 cycles per 128-bit block.
module sub_shift_rows (
  input  logic         clk,
  input  logic         reset,
  input  logic         decrypt_i,
  input  logic         start_i,
  input  logic [127:0] data_i,
  output logic [7:0]   sbox_data_o,
  output logic         sbox_decrypt_o,
  input  logic [7:0]   sbox_data_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [127:0] data_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] in_q, in_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q, out_d;
  logic         dec_q, dec_d;
  logic         rdy_q, rdy_d;

  logic [1:0]   row;
  logic [1:0]   col;
  logic [3:0]   src;
  logic [6:0]   src_lsb;
  logic [6:0]   dst_lsb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      work_q  <= '0;
      out_q   <= '0;
      dec_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      work_q  <= work_d;
      out_q   <= out_d;
      dec_q   <= dec_d;
      rdy_q   <= rdy_d;
    end
  end

  // Byte k sits at bits [127-8k -: 8]; 15-k is just ~k on 4 bits.
  assign dst_lsb = {~cnt_q, 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    work_d  = work_q;
    out_d   = out_q;
    dec_d   = dec_q;
    rdy_d   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start_i) begin
          in_d    = data_i;
          dec_d   = decrypt_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      (state_q == BUSY): begin
        work_d[dst_lsb +: 8] = sbox_data_i;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Last byte comes straight from the S-box, not the stale register.
          out_d   = {work_q[127:8], sbox_data_i};
          rdy_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row = cnt_q[1:0];
    col = cnt_q[3:2];
    if (dec_q) begin
      col = cnt_q[3:2] - row;
    end else begin
      col = cnt_q[3:2] + row;
    end
    src     = {col, row};
    src_lsb = {~src, 3'b000};
    sbox_data_o    = '0;
    sbox_decrypt_o = dec_q;
    busy_o         = 1'b0;
    if (state_q == BUSY) begin
      sbox_data_o = in_q[src_lsb +: 8];
      busy_o      = 1'b1;
    end
  end

  assign ready_o = rdy_q;
  assign data_o  = out_q;

endmodule

// File: tb/tb_sub_shift_rows.sv
// Scoreboard bench for sub_shift_rows with a behavioural S-box and
// a matrix-level SubBytes/ShiftRows reference model.
module tb_sub_shift_rows;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  typedef struct {
    logic [127:0] d;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         decrypt_i = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] data_i = '0;
  logic [7:0]   sbox_data_o;
  logic         sbox_decrypt_o;
  logic [7:0]   sbox_data_i;
  logic         busy_o;
  logic         ready_o;
  logic [127:0] data_o;

  logic [7:0]   inv_sb [256];
  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           m_cnt = 0;
  logic         m_dec = 1'b0;
  logic [127:0] m_dout = '0;

  sub_shift_rows dut (
    .clk            (clk),
    .reset          (reset),
    .decrypt_i      (decrypt_i),
    .start_i        (start_i),
    .data_i         (data_i),
    .sbox_data_o    (sbox_data_o),
    .sbox_decrypt_o (sbox_decrypt_o),
    .sbox_data_i    (sbox_data_i),
    .busy_o         (busy_o),
    .ready_o        (ready_o),
    .data_o         (data_o)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) inv_sb[SBOX[i]] = i[7:0];
  end

  assign sbox_data_i = sbox_decrypt_o ? inv_sb[sbox_data_o] : SBOX[sbox_data_o];

  // State as a 4x4 byte matrix: substitute every byte, then rotate rows.
  function automatic logic [127:0] ref_ssr(input logic [127:0] x, input logic dec);
    logic [7:0]   s [4][4];
    logic [7:0]   b;
    logic [127:0] y;
    int           cc;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b = x[127-8*(4*c+r) -: 8];
        s[r][c] = dec ? inv_sb[b] : SBOX[b];
      end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        cc = dec ? (c - r + 4) % 4 : (c + r) % 4;
        y[127-8*(4*c+r) -: 8] = s[r][cc];
      end
    return y;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      cyc++;
      if (m_cnt == 0 && start_i) begin
        q.push_back('{ref_ssr(data_i, decrypt_i), cyc + 16});
        m_cnt = 16;
        m_dec = decrypt_i;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
    end
  end

  always @(negedge reset) begin
    q.delete();
    m_cnt  = 0;
    m_dec  = 1'b0;
    m_dout = '0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (ready_o) begin
        if (q.size() == 0) begin
          chk("spurious_ready", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          chk("result", data_o, e.d);
          chk("latency", 128'(cyc), 128'(e.cyc));
          m_dout = e.d;
        end
      end else begin
        chk("hold", data_o, m_dout);
        if (q.size() > 0 && cyc > q[0].cyc) begin
          chk("missed_ready", 128'd0, 128'd1);
          void'(q.pop_front());
        end
      end
      chk("busy", 128'(busy_o), 128'(m_cnt != 0));
      if (m_cnt == 0) chk("sbox_idle", 128'(sbox_data_o), 128'd0);
      else chk("sbox_dec", 128'(sbox_decrypt_o), 128'(m_dec));
    end
  end

  task automatic issue(input logic [127:0] d, input logic dec);
    @(negedge clk);
    start_i   = 1'b1;
    data_i    = d;
    decrypt_i = dec;
    @(negedge clk);
    start_i   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || m_cnt != 0) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 60) chk("timeout", 128'd0, 128'd1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] va, vb;
    repeat (3) @(negedge clk);
    chk("rst_data", data_o, '0);
    chk("rst_ready", 128'(ready_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_sbox", 128'(sbox_data_o), 128'd0);
    chk("rst_sdec", 128'(sbox_decrypt_o), 128'd0);
    #2 reset = 1'b1;

    issue(FIPS_IN, 1'b0);
    wait_idle();
    chk("fips_enc", data_o, FIPS_OUT);

    issue(FIPS_OUT, 1'b1);
    wait_idle();
    chk("fips_dec", data_o, FIPS_IN);

    va = rnd128();
    issue(va, 1'b0);
    repeat (4) @(negedge clk);
    start_i   = 1'b1;
    data_i    = '0;
    decrypt_i = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    wait_idle();
    chk("busy_ignore", data_o, ref_ssr(va, 1'b0));

    va = rnd128();
    vb = rnd128();
    @(negedge clk);
    start_i = 1'b1;
    for (int i = 0; i < 4 * 17; i++) begin
      data_i    = i[0] ? va : vb;
      decrypt_i = 1'($urandom);
      @(negedge clk);
    end
    start_i = 1'b0;
    wait_idle();

    issue(rnd128(), 1'b1);
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_data", data_o, '0);
    chk("mid_rst_ready", 128'(ready_o), 128'd0);
    chk("mid_rst_busy", 128'(busy_o), 128'd0);
    @(negedge clk);
    #3 reset = 1'b1;
    issue(FIPS_IN, 1'b0);
    wait_idle();
    chk("post_rst", data_o, FIPS_OUT);

    repeat (50) @(negedge clk);
    #1;
    chk("idle_hold", data_o, FIPS_OUT);

    repeat (20) begin
      issue(rnd128(), 1'($urandom));
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
